bit_serial_feeder: RTL and testbench

BIT_SERIAL_FEEDER -- requirements
Module: bit_serial_feeder

---
 rtl/bit_serial_pkg.sv | 15 +
 rtl/bit_serial_operand_buf.sv | 83 ++++++++
 rtl/bit_serial_feeder.sv | 122 ++++++++++++
 tb/tb_bit_serial_feeder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// Shared constants and types for the bit-serial operand feeder.
// Holds the default operand width, round length and FSM state encoding.
package bit_serial_pkg;

  localparam int COMPUTE_CYCLE_DEF = 8;
  localparam int ROUND_DEF         = 128;
  // One lane's operand slice is one full operand word wide.
  localparam int LANE_W            = COMPUTE_CYCLE_DEF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_serial_operand_buf.sv
// Two-entry operand store: an active vector being serialised plus one pending vector.
// Next-state values are exported so the plane mux can register its outputs directly.
module bit_serial_operand_buf
  import bit_serial_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int SLICE_W = LANE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES*SLICE_W-1:0]   in_data,
  input  logic                       in_vld,
  input  logic                       consume,
  output logic                       in_rdy,
  output logic [LANES*SLICE_W-1:0]   act_data_nxt,
  output logic                       act_full_nxt
);

  localparam int W = LANES * SLICE_W;

  logic [W-1:0] act_data_r;
  logic         act_full_r;
  logic [W-1:0] pend_data_r;
  logic         pend_full_r;
  logic         rdy_r;

  logic [W-1:0] act_data_s;
  logic         act_full_s;
  logic [W-1:0] pend_data_s;
  logic         pend_full_s;
  logic         accept_s;

  // Next contents of the active/pending pair from accept and consume events.
  always_comb begin
    accept_s    = in_vld & rdy_r;
    act_data_s  = act_data_r;
    act_full_s  = act_full_r;
    pend_data_s = pend_data_r;
    pend_full_s = pend_full_r;
    if (consume && act_full_r) begin
      if (pend_full_r) begin
        act_data_s  = pend_data_r;
        pend_full_s = 1'b0;
      end else if (accept_s) begin
        act_data_s = in_data;
      end else begin
        act_full_s = 1'b0;
      end
    end else if (accept_s) begin
      if (!act_full_r) begin
        act_data_s = in_data;
        act_full_s = 1'b1;
      end else begin
        pend_data_s = in_data;
        pend_full_s = 1'b1;
      end
    end else begin
      act_full_s = act_full_r;
    end
  end

  // Storage registers; ready is held as state so it is low throughout reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_data_r  <= '0;
      act_full_r  <= 1'b0;
      pend_data_r <= '0;
      pend_full_r <= 1'b0;
      rdy_r       <= 1'b0;
    end else begin
      act_data_r  <= act_data_s;
      act_full_r  <= act_full_s;
      pend_data_r <= pend_data_s;
      pend_full_r <= pend_full_s;
      rdy_r       <= ~pend_full_s;
    end
  end

  assign in_rdy       = rdy_r;
  assign act_data_nxt = act_data_s;
  assign act_full_nxt = act_full_s;

endmodule

// File: rtl/bit_serial_feeder.sv
// Serialises two's-complement operand vectors into LSB-first bit-planes with
// sign-plane and end-of-round flags; every plane-side output is a register.
module bit_serial_feeder
  import bit_serial_pkg::*;
#(
  parameter int  LANES         = 8,
  parameter int  COMPUTE_CYCLE = COMPUTE_CYCLE_DEF,
  parameter int  ROUND         = ROUND_DEF,
  localparam int IDX_W         = (COMPUTE_CYCLE > 1) ? $clog2(COMPUTE_CYCLE) : 1,
  localparam int RND_W         = $clog2(ROUND) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES*COMPUTE_CYCLE-1:0] operand_vec,
  input  logic                       operand_vec_vld,
  output logic                       operand_vec_rdy,
  output logic [LANES-1:0]           bit_plane,
  output logic                       bit_plane_vld,
  input  logic                       bit_plane_rdy,
  output logic [IDX_W-1:0]           bit_plane_idx,
  output logic                       bit_plane_msb,
  output logic                       round_last
);

  state_t                         state_r, state_s;
  logic [IDX_W-1:0]               idx_r, idx_s;
  logic [RND_W-1:0]               rnd_r, rnd_s;
  logic [LANES-1:0]               plane_r, plane_s;
  logic                           msb_r, msb_s;
  logic                           last_r, last_s;
  logic                           plane_xfer_s;
  logic                           msb_xfer_s;
  logic [LANES*COMPUTE_CYCLE-1:0] act_data_nxt_s;
  logic                           act_full_nxt_s;

  assign plane_xfer_s = (state_r == SHIFT) & bit_plane_rdy;
  assign msb_xfer_s   = plane_xfer_s & (idx_r == IDX_W'(COMPUTE_CYCLE - 1));

  bit_serial_operand_buf #(
    .LANES   (LANES),
    .SLICE_W (COMPUTE_CYCLE)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .in_data      (operand_vec),
    .in_vld       (operand_vec_vld),
    .consume      (msb_xfer_s),
    .in_rdy       (operand_vec_rdy),
    .act_data_nxt (act_data_nxt_s),
    .act_full_nxt (act_full_nxt_s)
  );

  // FSM next state: SHIFT while an active vector exists.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (act_full_nxt_s) state_s = SHIFT;
        else                state_s = IDLE;
      end
      SHIFT: begin
        if (msb_xfer_s && !act_full_nxt_s) state_s = IDLE;
        else                               state_s = SHIFT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Plane index and round counter advance only on accepted planes.
  always_comb begin
    idx_s = idx_r;
    rnd_s = rnd_r;
    if (msb_xfer_s) begin
      idx_s = '0;
      rnd_s = (rnd_r == RND_W'(ROUND - 1)) ? '0 : rnd_r + RND_W'(1);
    end else if (plane_xfer_s) begin
      idx_s = idx_r + IDX_W'(1);
    end else begin
      idx_s = idx_r;
    end
  end

  // Next plane outputs are built from next-cycle state so they can be registered.
  always_comb begin
    plane_s = '0;
    if (state_s == SHIFT) begin
      for (int l = 0; l < LANES; l++) begin
        plane_s[l] = act_data_nxt_s[l*COMPUTE_CYCLE + int'(idx_s)];
      end
    end else begin
      plane_s = '0;
    end
    msb_s  = (state_s == SHIFT) && (idx_s == IDX_W'(COMPUTE_CYCLE - 1));
    last_s = msb_s && (rnd_s == RND_W'(ROUND - 1));
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= '0;
      rnd_r   <= '0;
      plane_r <= '0;
      msb_r   <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      rnd_r   <= rnd_s;
      plane_r <= plane_s;
      msb_r   <= msb_s;
      last_r  <= last_s;
    end
  end

  assign bit_plane     = plane_r;
  assign bit_plane_vld = (state_r == SHIFT);
  assign bit_plane_idx = idx_r;
  assign bit_plane_msb = msb_r;
  assign round_last    = last_r;

endmodule

// File: tb/tb_bit_serial_feeder.sv
// Scoreboard bench for bit_serial_feeder: expected planes are queued on vector
// acceptance and compared as the design presents them.
module tb_bit_serial_feeder;

  localparam int LANES = 8;
  localparam int CC    = 8;
  localparam int ROUND = 4;
  localparam int W     = LANES * CC;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   operand_vec;
  logic           operand_vec_vld;
  logic           operand_vec_rdy;
  logic [LANES-1:0] bit_plane;
  logic           bit_plane_vld;
  logic           bit_plane_rdy;
  logic [2:0]     bit_plane_idx;
  logic           bit_plane_msb;
  logic           round_last;

  always #5 clk = ~clk;

  bit_serial_feeder #(.LANES(LANES), .COMPUTE_CYCLE(CC), .ROUND(ROUND)) dut (
    .clk             (clk),
    .rst             (rst),
    .operand_vec     (operand_vec),
    .operand_vec_vld (operand_vec_vld),
    .operand_vec_rdy (operand_vec_rdy),
    .bit_plane       (bit_plane),
    .bit_plane_vld   (bit_plane_vld),
    .bit_plane_rdy   (bit_plane_rdy),
    .bit_plane_idx   (bit_plane_idx),
    .bit_plane_msb   (bit_plane_msb),
    .round_last      (round_last)
  );

  typedef struct {
    logic [LANES-1:0] plane;
    int               idx;
    bit               msb;
    bit               last;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] send_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int nvec, vec_seq, popped, accepts, vld_run, vld_run_max;
  logic [7:0]  lane0_seq, msb_seq;
  logic [15:0] rl_mask;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    send_q.delete();
    nvec = 0; vec_seq = 0; popped = 0; rl_mask = '0;
  endtask

  // One clock: drive, compare against the model, update the model, advance.
  task automatic tick();
    bit acc;
    logic [W-1:0] v;
    exp_t e;
    acc = (send_q.size() > 0) && (nvec < 2);
    if (send_q.size() > 0) begin
      operand_vec_vld = 1'b1;
      operand_vec     = send_q[0];
    end else begin
      operand_vec_vld = 1'b0;
      operand_vec     = '0;
    end
    check_val("plane_vld", 64'(bit_plane_vld), 64'(exp_q.size() != 0));
    check_val("vec_rdy", 64'(operand_vec_rdy), 64'(nvec < 2));
    if (exp_q.size() != 0) begin
      check_val("plane", 64'(bit_plane), 64'(exp_q[0].plane));
      check_val("idx", 64'(bit_plane_idx), 64'(exp_q[0].idx));
      check_val("msb", 64'(bit_plane_msb), 64'(exp_q[0].msb));
      check_val("round_last", 64'(round_last), 64'(exp_q[0].last));
      vld_run++;
      if (vld_run > vld_run_max) vld_run_max = vld_run;
      if (bit_plane_rdy) begin
        lane0_seq[exp_q[0].idx] = bit_plane[0];
        msb_seq[exp_q[0].idx]   = bit_plane_msb;
        if (exp_q[0].msb) begin
          if (round_last && popped < 16) rl_mask[popped] = 1'b1;
          popped++;
          nvec--;
        end
        void'(exp_q.pop_front());
      end
    end else begin
      check_val("idle_msb", 64'(bit_plane_msb), 64'd0);
      check_val("idle_last", 64'(round_last), 64'd0);
      vld_run = 0;
    end
    if (acc) begin
      v = send_q.pop_front();
      for (int i = 0; i < CC; i++) begin
        for (int l = 0; l < LANES; l++) e.plane[l] = v[l*CC + i];
        e.idx  = i;
        e.msb  = (i == CC - 1);
        e.last = (i == CC - 1) && ((vec_seq % ROUND) == ROUND - 1);
        exp_q.push_back(e);
      end
      vec_seq++;
      nvec++;
      accepts++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || send_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check_val("drain_done", 64'(exp_q.size() + send_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    operand_vec_vld = 1'b0;
    operand_vec = '0;
    clear_model();
    @(posedge clk); #1;
    check_val("rst_vld", 64'(bit_plane_vld), 64'd0);
    check_val("rst_plane", 64'(bit_plane), 64'd0);
    check_val("rst_idx", 64'(bit_plane_idx), 64'd0);
    check_val("rst_msb", 64'(bit_plane_msb), 64'd0);
    check_val("rst_last", 64'(round_last), 64'd0);
    check_val("rst_rdy", 64'(operand_vec_rdy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_rdy", 64'(operand_vec_rdy), 64'd1);
    check_val("post_rst_vld", 64'(bit_plane_vld), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    operand_vec = '0;
    operand_vec_vld = 1'b0;
    bit_plane_rdy = 1'b1;
    accepts = 0; vld_run = 0; vld_run_max = 0;
    clear_model();
    @(posedge clk); #1;
    do_reset();

    // Plane order: lane0 = A5
    lane0_seq = '0; msb_seq = '0;
    send_q.push_back(64'h0000_0000_0000_00A5);
    drain();
    check_val("lane0_seq", 64'(lane0_seq), 64'hA5);
    check_val("msb_only_idx7", 64'(msb_seq), 64'h80);

    // Stall for 5 cycles at idx 3
    send_q.push_back({$urandom, $urandom});
    n = 0;
    while (!(bit_plane_vld && bit_plane_idx == 3'd3) && n < 20) begin tick(); n++; end
    check_val("reach_idx3", 64'(bit_plane_idx), 64'd3);
    bit_plane_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("stall_idx", 64'(bit_plane_idx), 64'd3);
      check_val("stall_vld", 64'(bit_plane_vld), 64'd1);
      if (exp_q.size() != 0) check_val("stall_plane", 64'(bit_plane), 64'(exp_q[0].plane));
      else check_val("stall_model", 64'(exp_q.size()), 64'd8);
    end
    bit_plane_rdy = 1'b1;
    tick();
    check_val("after_stall_idx", 64'(bit_plane_idx), 64'd4);
    drain();

    // Streaming of three vectors
    vld_run = 0; vld_run_max = 0;
    for (int k = 0; k < 3; k++) send_q.push_back({$urandom, $urandom});
    drain();
    check_val("stream_run", 64'(vld_run_max), 64'd24);

    // Backpressure: only two vectors fit
    bit_plane_rdy = 1'b0;
    accepts = 0;
    for (int k = 0; k < 3; k++) send_q.push_back({$urandom, $urandom});
    for (int k = 0; k < 8; k++) tick();
    check_val("bp_accepts", 64'(accepts), 64'd2);
    check_val("bp_rdy", 64'(operand_vec_rdy), 64'd0);
    bit_plane_rdy = 1'b1;
    drain();

    // Round flag over nine vectors
    do_reset();
    for (int k = 0; k < 9; k++) send_q.push_back({$urandom, $urandom});
    drain();
    check_val("round_mask", 64'(rl_mask), 64'h0088);

    // Reset with pending full at idx 5
    for (int k = 0; k < 2; k++) send_q.push_back({$urandom, $urandom});
    n = 0;
    while (!(bit_plane_vld && bit_plane_idx == 3'd5) && n < 20) begin tick(); n++; end
    check_val("pre_rst_pending", 64'(operand_vec_rdy), 64'd0);
    do_reset();
    send_q.push_back({$urandom, $urandom});
    tick();
    check_val("restart_idx", 64'(bit_plane_idx), 64'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
